// File: rtl/player_board.sv
// Per-player Battleship board: holds the live ship map and the opponent's attack
// history, validates each attack, and resolves it to hit/miss with a setup/armed/dead FSM.
module player_board #(
    parameter int CELLS      = 16,
    parameter bit CUMULATIVE = 1'b1,
    parameter int CNT_W      = $clog2(CELLS + 1)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             place_vld,
    input  logic [CELLS-1:0] place_map,
    input  logic             start,
    input  logic             atk_vld,
    input  logic [CELLS-1:0] atk_map,
    output logic [1:0]       state,
    output logic             alive,
    output logic             atk_ok,
    output logic             atk_err,
    output logic             hit,
    output logic             miss,
    output logic [CNT_W-1:0] ships_left,
    output logic [CNT_W-1:0] shots,
    output logic [CELLS-1:0] hist_map
);

    typedef enum logic [1:0] {
        SETUP = 2'b00,
        ARMED = 2'b01,
        DEAD  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CELLS-1:0] ship_q, ship_d;
    logic [CELLS-1:0] hist_q, hist_d;
    logic [CNT_W-1:0] shots_q, shots_d;
    logic             ok_q, ok_d, err_q, err_d, hit_q, hit_d, miss_q, miss_d;
    logic [CELLS-1:0] new_cell;
    logic             atk_legal;

    function automatic logic [CNT_W-1:0] popcount(input logic [CELLS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < CELLS; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    // An attack is a handshake with no back-pressure: atk_vld is sampled every
    // cycle in ARMED and answered one cycle later by exactly one of atk_ok/atk_err.
    always_comb begin
        if (CUMULATIVE) begin
            new_cell  = atk_map & ~hist_q;
            atk_legal = (popcount(new_cell) == CNT_W'(1)) && ((atk_map & hist_q) == hist_q);
        end else begin
            new_cell  = atk_map;
            atk_legal = (popcount(atk_map) == CNT_W'(1)) && ((atk_map & hist_q) == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        ship_d  = ship_q;
        hist_d  = hist_q;
        shots_d = shots_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        case (state_q)
            SETUP: begin
                if (place_vld) begin
                    ship_d = place_map;
                end else if (start) begin
                    if (ship_q != '0) state_d = ARMED;
                    else              err_d   = 1'b1;
                end
            end
            ARMED: begin
                if (atk_vld) begin
                    if (atk_legal) begin
                        hist_d = hist_q | new_cell;
                        hit_d  = |(new_cell & ship_q);
                        miss_d = ~hit_d;
                        ship_d = ship_q & ~new_cell;
                        ok_d   = 1'b1;
                        if (shots_q != CNT_W'(CELLS)) shots_d = shots_q + CNT_W'(1);
                        if (ship_d == '0) state_d = DEAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= SETUP;
            ship_q  <= '0;
            hist_q  <= '0;
            shots_q <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ship_q  <= ship_d;
            hist_q  <= hist_d;
            shots_q <= shots_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign state      = state_q;
    assign alive      = (state_q == ARMED);
    assign atk_ok     = ok_q;
    assign atk_err    = err_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign ships_left = popcount(ship_q);
    assign shots      = shots_q;
    assign hist_map   = hist_q;

endmodule
